// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier family.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam int MUL_WIDTH  = 16;
    localparam int PROD_WIDTH = 32;

endpackage

// File: rtl/carry_lookahead_adder32.sv
// Library 32-bit adder: 4-bit carry-lookahead groups, group carries chained.
module carry_lookahead_adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum,
    output logic        C0
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    always_comb begin
        g = A & B;
        p = A ^ B;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+4] = g[4*i+3] | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
        end
        Sum = p ^ c[31:0];
        C0  = c[32];
    end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier sharing one 32-bit CLA.
// Define SHIFT_ADD_EARLY_TERM_EN to leave BUSY once no multiplier bits remain.
import mul_pkg::*;

module shift_add_mul_ctrl #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PROD_WIDTH-1:0] product,
    output logic                  busy
);

    generate
        if (WIDTH != MUL_WIDTH) begin : g_width_check
            $error("shift_add_mul_ctrl: WIDTH must be 16 to match the 32-bit adder");
        end
    endgenerate

    mul_state_t state, state_next;

    logic [PROD_WIDTH-1:0] acc;
    logic [PROD_WIDTH-1:0] mcand;
    logic [PROD_WIDTH-1:0] addend;
    logic [PROD_WIDTH-1:0] sum;
    logic [WIDTH-1:0]      mplier;
    logic [3:0]            cnt;
    logic                  carry_unused;
    logic                  last_iter;

    assign addend = mplier[0] ? mcand : '0;

    // The product always fits in 32 bits, so the carry-out is never set.
    carry_lookahead_adder32 u_adder (
        .A   (acc),
        .B   (addend),
        .Sum (sum),
        .C0  (carry_unused)
    );

`ifdef SHIFT_ADD_EARLY_TERM_EN
    assign last_iter = (mplier[WIDTH-1:1] == '0) || (cnt == 4'd15);
`else
    assign last_iter = (cnt == 4'd15);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= {{(PROD_WIDTH-WIDTH){1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign product   = acc;

endmodule

// File: doc/shift_add_mul_ctrl.md
# shift_add_mul_ctrl

Sequential 16x16 unsigned multiplier controller. It sequences a single shared `carry_lookahead_adder32` through one shift-and-add iteration per clock and accumulates a 32-bit product. It takes operands through a valid/ready handshake and returns the product through a second valid/ready handshake. It sits beside the Wallace-tree multiplier as the low-area alternative and reuses the existing adder library unchanged.

## Interface
- `WIDTH`, 16: operand width. Only 16 is legal, because the product width `2*WIDTH` must equal the 32-bit adder width. Elaboration fails on any other value.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`/`b` valid.
- `in_ready`  out  1  controller can accept operands.
- `a`  in  16  multiplicand, unsigned.
- `b`  in  16  multiplier, unsigned.
- `out_valid`  out  1  `product` valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  32  `a*b`.
- `busy`  out  1  iteration in progress.

## Operation
- States: IDLE, BUSY, DONE.
- Registers:
  - `acc[31:0]`
  - `mcand[31:0]`: multiplicand, shifted left each iteration
  - `mplier[15:0]`: multiplier, shifted right each iteration
  - `cnt[3:0]`
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: `acc`<=0, `mcand`<={16'b0,a}, `mplier`<=b, `cnt`<=0, go to BUSY.
- BUSY, every edge:
  - `acc`<=adder.Sum, where the adder inputs are A=`acc`, B=(`mplier[0]` ? `mcand` : 0).
  - `mcand`<<=1, `mplier`>>=1, `cnt`++.
  - Go to DONE on the edge where `cnt`==15.
- DONE:
  - `out_valid`=1 and `product`=`acc`, both held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- Adder carry-out C0 is unused. It is provably 0, because the product fits in 32 bits. The bench asserts C0==0 in BUSY.
- `in_valid` outside IDLE is ignored: no state change, and the operands are not captured.
- `out_ready` outside DONE is ignored.
- Output functions: `busy`=(state==BUSY), `in_ready`=(state==IDLE), `out_valid`=(state==DONE).
- Reset (asynchronous, any state, including mid-BUSY):
  - state<=IDLE.
  - `acc`, `mcand`, `mplier`, `cnt` <= 0.
  - Any in-flight operation is discarded and never produces a result.
- Output values during and after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0.
- No transfer is taken while `rst_n` is low.

## Timing
- Accept edge E0: state becomes BUSY.
- BUSY occupies 16 cycles; DONE is entered at edge E16.
- `out_valid` is first high in the cycle after E16. Latency from accept to result is 16 cycles, with EARLY_TERM_EN undefined.
- Output handshake at edge Ek moves the state to IDLE. `in_ready` is high from the next cycle; there is no same-cycle bypass from DONE to an accept.
- Minimum throughput: one multiply per 18 cycles (accept, 16 BUSY, 1 DONE).
- `product` is registered and does not change while `out_valid`=1.

## Configuration
- `SHIFT_ADD_EARLY_TERM_EN` undefined: BUSY always lasts exactly 16 cycles, independent of `b`.
- `SHIFT_ADD_EARLY_TERM_EN` defined: BUSY exits to DONE on the edge where (`mplier`>>1)==0 or `cnt`==15, whichever comes first.
  - BUSY cycles = index of the highest set bit of `b` + 1.
  - `b`==0 or `b`==1 gives 1 BUSY cycle.
- The `product` value is identical in both builds.

## Structure
- Shared package `mul_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t`
  - `localparam MUL_WIDTH = 16`
  - `localparam PROD_WIDTH = 32`
- One sub-module: existing `carry_lookahead_adder32`, instantiated once and not modified.
- FSM, shift registers and counter live in `shift_add_mul_ctrl`.

## Test plan
- Basic multiply: a=3, b=5, `out_ready`=1 → `product`=15 (0x0000000F), and `out_valid` rises exactly 16 cycles after accept (EARLY_TERM_EN undefined).
- Maximum operands: a=0xFFFF, b=0xFFFF → `product`=0xFFFE0001; C0 stays 0 throughout BUSY.
- Output backpressure: a=0x1234, b=0x0010 → `product`=0x00012340. With `out_ready` held low 5 cycles, `out_valid` and `product` remain stable, and `in_ready` stays 0 until the handshake.
- Input protocol: `in_valid` pulsed with a=7, b=9 during BUSY of a=2, b=2 → result 4. The 7x9 pair is not captured; `in_ready` returns 1 the cycle after the output handshake.
- Reset mid-operation: `rst_n` low at BUSY cycle 8 → immediate IDLE with `in_ready`=1, `out_valid`=0, `product`=0. A new a=10, b=10 then yields 100.
- Early termination (EARLY_TERM_EN defined):
  - b=0, a=0xFFFF → 1 BUSY cycle, `product`=0.
  - b=0x0008, a=0x0003 → 4 BUSY cycles, `product`=0x18.
